mode3_exp_ctrl: RTL and testbench
=================================

// Module: mode3_exp_ctrl
// PURPOSE
// Sequencer for the 4-lane mode-3 exponent stage. On start, streams a vector of LEN elements from
// a local SRAM through the 4 exp lanes and writes the results to a destination SRAM. It generates
// read addresses and tracks in-flight beats; an output FIFO with credit-based issue absorbs
// write-side back-pressure. Sits between the softmax top-level FSM and the mode3_exp datapath.
// PARAMETERS
// DW        16  lane data width (= `DATAWIDTH)
// AW        10  SRAM address width; one address holds one 4-lane beat (4*DW bits)
// LW        16  width of element-count input
// EXP_LAT    1  register stages between exp_inp* and exp_outp* sampling (0..3)
// FIFO_D     4  output FIFO depth in beats; must be >= EXP_LAT+2
// PORTS
// clk          in   1      clock, rising edge
// reset        in   1      async active-high reset
// start        in   1      1-cycle pulse; accepted only in IDLE
// len          in   LW     element count, sampled on start
// src_base     in   AW     source beat address, sampled on start
// dst_base     in   AW     destination beat address, sampled on start
// rd_en        out  1      SRAM read strobe; data returns exactly 1 cycle later
// rd_addr      out  AW     read beat address
// rd_data      in   4*DW   read beat; lane0 = [DW-1:0]
// exp_inp      out  4*DW   lanes to exp units (registered)
// exp_outp     in   4*DW   exp unit results, valid EXP_LAT cycles after exp_inp
// wr_en        out  1      write strobe; a beat transfers when wr_en && wr_ready
// wr_ready     in   1      destination accepts a beat
// wr_addr      out  AW     write beat address
// wr_data      out  4*DW   result beat
// wr_mask      out  4      per-lane write enable (bit i = lane i)
// busy         out  1      high from the cycle after start is accepted until done
// done         out  1      1-cycle pulse after the last beat is written
// BEHAVIOUR
// - Reset: state=IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, exp_inp, wr_data = 0;
//   wr_mask = 0; FIFO empty; all counters 0. Reset mid-run aborts: no further reads or writes, no done.
// - nbeats = ceil(len/4); rem = len mod 4. If rem != 0, the final beat has mask = (1<<rem)-1;
//   otherwise the mask is 4'hF. Inactive lanes drive 0 on exp_inp and hold mask=0.
// - FSM: IDLE -start&&len!=0-> RUN; IDLE -start&&len==0-> DONE (done pulses the next cycle; no
//   SRAM traffic). RUN -last read issued-> DRAIN; DRAIN -FIFO empty && nothing in flight-> DONE;
//   DONE -> IDLE (done=1 for exactly this one cycle). start outside IDLE is ignored.
// - Issue rule: in RUN, rd_en=1 iff inflight + fifo_count < FIFO_D. inflight counts beats issued
//   but not yet pushed into the FIFO (at most EXP_LAT+1). rd_addr = src_base + issued index,
//   with AW-bit wrap-around (no error).
// - Pipeline: read at T; rd_data registered into exp_inp at T+1; exp_outp sampled at T+1+EXP_LAT
//   and pushed to the FIFO together with its mask. Issue never stalls an in-flight beat.
// - Write: wr_en = !fifo_empty. wr_data/wr_mask come from the FIFO head. wr_addr = dst_base + the
//   number of beats written so far (wraps). Pop on wr_en && wr_ready. A push and a pop in the same
//   cycle leave fifo_count unchanged. The FIFO never overflows by construction; an overflow-guard
//   assertion is included for simulation only.
// - Minimum latency with wr_ready tied high: first wr_en at start+3+EXP_LAT.
//   Steady state: 1 beat per cycle.
// CONFIGURATION
// MODE3_CTRL_PERF_EN defined: adds output cyc_cnt [31:0]. It clears on an accepted start, counts
//   every cycle while busy, and holds its value after done. It also adds stall_cnt [31:0], which
//   counts cycles with wr_en && !wr_ready.
// MODE3_CTRL_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
// T1 len=8, src=0, dst=0x20, wr_ready=1, EXP_LAT=1 -> reads at addr 0,1 back-to-back; writes to
//    0x20,0x21 with mask F,F; done pulses 1 cycle after the 2nd write; busy covers the whole run.
// T2 len=6 -> 2 beats; 2nd beat mask=4'b0011, exp_inp lanes 2,3 = 0.
//    len=0 -> done 1 cycle after start, rd_en and wr_en never asserted.
// T3 len=64, wr_ready held low 20 cycles after the first wr_en -> rd_en stops once
//    inflight+fifo=FIFO_D; no beat lost or duplicated. Compare all 16 written beats to a golden exp.
// T4 src_base=2^AW-1, len=8 -> rd_addr sequence is 2^AW-1 then 0; dst wraps the same way.
// T5 reset asserted during RUN with 3 beats in flight -> all outputs reach reset values immediately,
//    no further writes, no done. A new start then completes normally.
// T6 start pulsed during RUN/DRAIN -> ignored. With MODE3_CTRL_PERF_EN defined, T3 gives
//    stall_cnt=20 and cyc_cnt = total busy cycles.

Source files
------------

// File: rtl/mode3_exp_ctrl.sv
// Sequencer for the 4-lane mode-3 exponent stage: SRAM read -> exp lanes -> output FIFO -> SRAM write.
// Define MODE3_CTRL_PERF_EN to add the cyc_cnt/stall_cnt performance counters.
module mode3_exp_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int LW      = 16,
  parameter int EXP_LAT = 1,
  parameter int FIFO_D  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic [AW-1:0]   src_base,
  input  logic [AW-1:0]   dst_base,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [4*DW-1:0] rd_data,
  output logic [4*DW-1:0] exp_inp,
  input  logic [4*DW-1:0] exp_outp,
  output logic            wr_en,
  input  logic            wr_ready,
  output logic [AW-1:0]   wr_addr,
  output logic [4*DW-1:0] wr_data,
  output logic [3:0]      wr_mask,
  output logic            busy,
  output logic            done
`ifdef MODE3_CTRL_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  // Write handshake: a beat moves on every cycle where wr_en && wr_ready; wr_en stays high
  // while the FIFO holds data and wr_data/wr_mask are stable until the beat is taken.
  localparam int BW = 4 * DW;
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_D - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] src_q, dst_q, wr_idx;
  logic [LW-1:0] nbeats_q, rd_idx;
  logic [1:0]    rem_q;
  logic [CW-1:0] inflight, fifo_count;
  logic [EXP_LAT:0] pipe_v;
  logic [3:0]    pipe_m [EXP_LAT+1];
  logic [BW+3:0] fifo_mem [FIFO_D];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [BW+3:0] head;
  logic [3:0]    cur_mask;
  logic          accept, last_beat, last_rd, push, pop, fifo_empty, drain_done;

  assign accept     = start && (state == S_IDLE);
  assign last_beat  = (rd_idx == nbeats_q - LW'(1));
  assign rd_en      = (state == S_RUN) &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_D));
  assign last_rd    = rd_en && last_beat;
  assign rd_addr    = src_q + AW'(rd_idx);
  assign push       = pipe_v[EXP_LAT];
  assign fifo_empty = (fifo_count == '0);
  assign wr_en      = !fifo_empty;
  assign pop        = wr_en && wr_ready;
  assign head       = fifo_mem[rd_ptr];
  assign wr_data    = wr_en ? head[BW-1:0] : '0;
  assign wr_mask    = wr_en ? head[BW+3:BW] : '0;
  assign wr_addr    = dst_q + wr_idx;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  // The last FIFO entry leaving this cycle counts as empty so done follows the final write directly.
  assign drain_done = (inflight == '0) && (fifo_empty || (fifo_count == CW'(1) && pop));

  always_comb begin
    cur_mask = 4'hF;
    if (last_beat) begin
      case (rem_q)
        2'd1:    cur_mask = 4'b0001;
        2'd2:    cur_mask = 4'b0011;
        2'd3:    cur_mask = 4'b0111;
        default: cur_mask = 4'hF;
      endcase
    end
  end

  // rd_data is the SRAM's own output register; stage 0 of the tracking pipe marks it valid.
  always_comb begin
    exp_inp = '0;
    for (int i = 0; i < 4; i++) begin
      if (pipe_v[0] && pipe_m[0][i]) exp_inp[i*DW +: DW] = rd_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = (len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (last_rd) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      nbeats_q   <= '0;
      rem_q      <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pipe_v     <= '0;
      for (int i = 0; i <= EXP_LAT; i++) pipe_m[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        nbeats_q <= LW'(({1'b0, len} + (LW+1)'(3)) >> 2);
        rem_q    <= len[1:0];
        rd_idx   <= '0;
        wr_idx   <= '0;
      end else begin
        if (rd_en) rd_idx <= rd_idx + LW'(1);
        if (pop)   wr_idx <= wr_idx + AW'(1);
      end
      pipe_v[0] <= rd_en;
      pipe_m[0] <= cur_mask;
      for (int i = 1; i <= EXP_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_m[i] <= pipe_m[i-1];
      end
      if (rd_en && !push)      inflight <= inflight + CW'(1);
      else if (!rd_en && push) inflight <= inflight - CW'(1);
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_m[EXP_LAT], exp_outp};
  end

  // Issue credit keeps inflight + fifo_count <= FIFO_D, so a push into a full FIFO is a design bug.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_count == CW'(FIFO_D))));

`ifdef MODE3_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (accept) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy)               cyc_cnt   <= cyc_cnt + 32'd1;
      if (wr_en && !wr_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mode3_exp_ctrl.sv
// Directed bench for mode3_exp_ctrl with a 1-cycle SRAM model, a 1-stage exp model and a write logger.
module tb_mode3_exp_ctrl;
  localparam int DW = 16, AW = 10, LW = 16, EXP_LAT = 1, FIFO_D = 4;

  logic        clk = 0, reset = 1, start = 0, wr_ready = 1;
  logic [15:0] len = '0;
  logic [9:0]  src_base = '0, dst_base = '0;
  logic        rd_en, wr_en, busy, done;
  logic [9:0]  rd_addr, wr_addr;
  logic [63:0] rd_data = '0, exp_outp = '0, exp_inp, wr_data;
  logic [3:0]  wr_mask;

  int checks = 0, failures = 0;
  logic [63:0] src_mem [1024];
  logic [63:0] exp_q[$];
  logic [63:0] wr_data_log[$], exp_inp_log[$];
  logic [9:0]  rd_addr_log[$], wr_addr_log[$];
  logic [3:0]  wr_mask_log[$];
  int          rd_k_log[$], wr_k_log[$];
  int          done_k, done_cnt, busy_err, max_outs, stalled, traffic;
  bit          timed_out;

  mode3_exp_ctrl #(.DW(DW), .AW(AW), .LW(LW), .EXP_LAT(EXP_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .exp_inp(exp_inp), .exp_outp(exp_outp),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy), .done(done)
  );

  // ---------------- clock / environment models ----------------
  always #5 clk = ~clk;

  function automatic logic [63:0] fexp4(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = x[i*16 +: 16] * 16'd3 + 16'h0101;
    return r;
  endfunction

  function automatic logic [63:0] lane_bits(input logic [3:0] m);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = {16{m[i]}};
    return r;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];
  always @(posedge clk) exp_outp <= fexp4(exp_inp);

  // ---------------- driver: one job, logging every cycle ----------------
  task automatic run_job(input logic [15:0] l, input logic [9:0] s, input logic [9:0] d,
                         input int stall, input int glitch_at, input int abort_at);
    int rd_n, wr_n;
    rd_n = 0; wr_n = 0;
    rd_addr_log.delete(); wr_addr_log.delete(); wr_mask_log.delete(); wr_data_log.delete();
    rd_k_log.delete(); wr_k_log.delete(); exp_inp_log.delete(); exp_q.delete();
    done_k = -1; done_cnt = 0; busy_err = 0; max_outs = 0; stalled = 0; traffic = 0; timed_out = 0;
    @(posedge clk); #1;
    start = 1; len = l; src_base = s; dst_base = d; wr_ready = (stall == 0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      exp_inp_log.push_back(exp_inp);
      if (busy !== (k >= 1)) busy_err++;
      if (rd_en) begin rd_addr_log.push_back(rd_addr); rd_k_log.push_back(k); rd_n++; end
      if (rd_n - wr_n > max_outs) max_outs = rd_n - wr_n;
      if (wr_en) begin
        if (wr_ready) begin
          wr_addr_log.push_back(wr_addr); wr_mask_log.push_back(wr_mask);
          wr_data_log.push_back(wr_data); wr_k_log.push_back(k); wr_n++;
        end else stalled++;
      end
      if (rd_en || wr_en) traffic++;
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      @(posedge clk); #1;
      start = (k + 1 == glitch_at);
      if (start) begin len = 16'd4; src_base = 10'h3F0; end
      wr_ready = (stall == 0) || (stalled >= stall);
      if (k + 1 == abort_at) begin reset = 1; return; end
      if (done_k >= 0) return;
    end
    timed_out = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {rd_en, wr_en, busy, done});
    end
    checks++;
    if ({rd_addr, wr_addr, wr_mask} !== 24'h0 || exp_inp !== 64'h0 || wr_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_values got rd_addr=%h wr_addr=%h mask=%h exp_inp=%h wr_data=%h exp=0",
               rd_addr, wr_addr, wr_mask, exp_inp, wr_data);
    end
    @(posedge clk); #1; reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=0000", {rd_en, wr_en, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [63:0] e, m;
    run_job(16'd8, 10'h000, 10'h020, 0, -1, -1);
    checks++;
    if (timed_out || done_cnt != 1) begin
      failures++; $display("FAIL t1_done got_cnt=%0d timeout=%0d exp_cnt=1", done_cnt, timed_out);
    end
    checks++;
    if (rd_addr_log.size() != 2 || rd_addr_log[0] !== 10'h000 || rd_addr_log[1] !== 10'h001 ||
        rd_k_log[0] != 1 || rd_k_log[1] != 2) begin
      failures++; $display("FAIL t1_reads got_n=%0d exp reads at 0,1 in cycles 1,2", rd_addr_log.size());
    end
    checks++;
    if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 10'h020 || wr_addr_log[1] !== 10'h021 ||
        wr_mask_log[0] !== 4'hF || wr_mask_log[1] !== 4'hF) begin
      failures++; $display("FAIL t1_writes got_n=%0d exp 0x20/0x21 mask F", wr_addr_log.size());
    end
    checks++;
    if (wr_k_log.size() != 2 || wr_k_log[0] != 3 + EXP_LAT || wr_k_log[1] != 4 + EXP_LAT) begin
      failures++; $display("FAIL t1_latency got_first=%0d exp=%0d", wr_k_log.size() ? wr_k_log[0] : -1, 3 + EXP_LAT);
    end
    checks++;
    if (done_k != 6) begin failures++; $display("FAIL t1_done_cycle got=%0d exp=6", done_k); end
    checks++;
    if (busy_err != 0) begin failures++; $display("FAIL t1_busy got_errs=%0d exp=0", busy_err); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL t1_after_done got busy=%b done=%b exp=0,0", busy, done);
    end
    for (int b = 0; b < 2; b++) exp_q.push_back(fexp4(src_mem[10'(b)]));
    for (int b = 0; b < wr_data_log.size(); b++) begin
      e = exp_q.pop_front(); m = lane_bits(4'hF);
      checks++;
      if ((wr_data_log[b] & m) !== (e & m)) begin
        failures++; $display("FAIL t1_data[%0d] got=%h exp=%h", b, wr_data_log[b], e);
      end
    end
  endtask

  task automatic test_partial();
    logic [63:0] e, m, src1;
    run_job(16'd6, 10'h040, 10'h100, 0, -1, -1);
    checks++;
    if (timed_out || wr_mask_log.size() != 2 || wr_mask_log[0] !== 4'hF || wr_mask_log[1] !== 4'b0011) begin
      failures++; $display("FAIL t2_masks got_n=%0d last=%h exp=F,3", wr_mask_log.size(),
                           wr_mask_log.size() ? wr_mask_log[wr_mask_log.size()-1] : 4'hx);
    end
    src1 = src_mem[10'h041];
    checks++;
    if (rd_k_log.size() != 2 || exp_inp_log[rd_k_log[1] + 1] !== {32'h0, src1[31:0]}) begin
      failures++; $display("FAIL t2_exp_inp got=%h exp=%h",
                           rd_k_log.size() == 2 ? exp_inp_log[rd_k_log[1] + 1] : 64'hx, {32'h0, src1[31:0]});
    end
    exp_q.push_back(fexp4(src_mem[10'h040]));
    exp_q.push_back(fexp4(src1));
    for (int b = 0; b < wr_data_log.size(); b++) begin
      e = exp_q.pop_front(); m = lane_bits(b == 1 ? 4'b0011 : 4'hF);
      checks++;
      if ((wr_data_log[b] & m) !== (e & m)) begin
        failures++; $display("FAIL t2_data[%0d] got=%h exp=%h", b, wr_data_log[b] & m, e & m);
      end
    end
  endtask

  task automatic test_zero_len();
    run_job(16'd0, 10'h005, 10'h005, 0, -1, -1);
    checks++;
    if (timed_out || done_k != 1 || done_cnt != 1) begin
      failures++; $display("FAIL t2_len0_done got_cycle=%0d exp=1", done_k);
    end
    checks++;
    if (traffic != 0) begin failures++; $display("FAIL t2_len0_traffic got=%0d exp=0", traffic); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL t2_len0_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    int bad;
    run_job(16'd64, 10'h010, 10'h200, 20, -1, -1);
    checks++;
    if (timed_out || done_cnt != 1 || stalled != 20) begin
      failures++; $display("FAIL t3_run got_done=%0d stalled=%0d exp=1,20", done_cnt, stalled);
    end
    checks++;
    if (max_outs != FIFO_D) begin
      failures++; $display("FAIL t3_credit got_max_outstanding=%0d exp=%0d", max_outs, FIFO_D);
    end
    checks++;
    if (rd_addr_log.size() != 16 || wr_addr_log.size() != 16) begin
      failures++; $display("FAIL t3_counts got_rd=%0d wr=%0d exp=16,16", rd_addr_log.size(), wr_addr_log.size());
    end
    bad = 0;
    for (int b = 0; b < wr_addr_log.size(); b++) begin
      if (wr_addr_log[b] !== 10'(10'h200 + b) || wr_mask_log[b] !== 4'hF) bad++;
      if (b < rd_addr_log.size() && rd_addr_log[b] !== 10'(10'h010 + b)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL t3_addr_seq got_bad=%0d exp=0", bad); end
    for (int b = 0; b < 16; b++) exp_q.push_back(fexp4(src_mem[10'(10'h010 + b)]));
    for (int b = 0; b < wr_data_log.size(); b++) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_data_log[b] !== e) begin
        failures++; $display("FAIL t3_data[%0d] got=%h exp=%h", b, wr_data_log[b], e);
      end
    end
  endtask

  task automatic test_wrap();
    run_job(16'd8, 10'h3FF, 10'h3FF, 0, -1, -1);
    checks++;
    if (timed_out || rd_addr_log.size() != 2 || rd_addr_log[0] !== 10'h3FF || rd_addr_log[1] !== 10'h000) begin
      failures++; $display("FAIL t4_rd_wrap got_n=%0d exp 3FF,000", rd_addr_log.size());
    end
    checks++;
    if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 10'h3FF || wr_addr_log[1] !== 10'h000) begin
      failures++; $display("FAIL t4_wr_wrap got_n=%0d exp 3FF,000", wr_addr_log.size());
    end
  endtask

  task automatic test_abort();
    int bad;
    run_job(16'd32, 10'h080, 10'h300, 0, -1, 4);
    #1;
    checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0 || rd_addr !== 10'h0 || wr_addr !== 10'h0 ||
        exp_inp !== 64'h0 || wr_data !== 64'h0 || wr_mask !== 4'h0) begin
      failures++; $display("FAIL t5_async_reset got strobes=%b rd_addr=%h wr_addr=%h exp=0",
                           {rd_en, wr_en, busy, done}, rd_addr, wr_addr);
    end
    checks++;
    if (rd_addr_log.size() != 3 || wr_addr_log.size() != 0) begin
      failures++; $display("FAIL t5_before_abort got_rd=%0d wr=%0d exp=3,0", rd_addr_log.size(), wr_addr_log.size());
    end
    bad = 0;
    repeat (2) begin @(negedge clk); if (rd_en || wr_en || done || busy) bad++; end
    @(posedge clk); #1; reset = 0;
    repeat (6) begin @(negedge clk); if (rd_en || wr_en || done || busy) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL t5_quiet_after_abort got=%0d exp=0", bad); end
    run_job(16'd8, 10'h080, 10'h300, 0, -1, -1);
    checks++;
    if (timed_out || done_cnt != 1 || wr_addr_log.size() != 2 || wr_addr_log[0] !== 10'h300 || done_k != 6) begin
      failures++; $display("FAIL t5_restart got_wr=%0d done_cycle=%0d exp=2,6", wr_addr_log.size(), done_k);
    end
  endtask

  task automatic test_start_ignored();
    run_job(16'd20, 10'h050, 10'h060, 0, 3, -1);
    checks++;
    if (timed_out || done_cnt != 1 || done_k != 9 || rd_addr_log.size() != 5 || rd_addr_log[4] !== 10'h054) begin
      failures++; $display("FAIL t6_run_glitch got_done=%0d cycle=%0d rd=%0d exp=1,9,5",
                           done_cnt, done_k, rd_addr_log.size());
    end
    checks++;
    if (wr_addr_log.size() != 5 || wr_addr_log[4] !== 10'h064) begin
      failures++; $display("FAIL t6_run_writes got=%0d exp=5", wr_addr_log.size());
    end
    run_job(16'd8, 10'h050, 10'h060, 0, 4, -1);
    checks++;
    if (timed_out || done_cnt != 1 || done_k != 6 || rd_addr_log.size() != 2 || wr_addr_log.size() != 2) begin
      failures++; $display("FAIL t6_drain_glitch got_cycle=%0d rd=%0d wr=%0d exp=6,2,2",
                           done_k, rd_addr_log.size(), wr_addr_log.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++; $display("FAIL t6_idle_after got busy=%b rd_en=%b exp=0,0", busy, rd_en);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) src_mem[a] = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
    test_reset();
    test_basic();
    test_partial();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_abort();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
